// File: rtl/rou_pkg.sv
// rou_pkg: shared roubus definitions used by the tx stage, the rx stage and the
// other roubus stages.
//   KIND_*      2-bit flit kind field values (KIND_EMPTY = bus empty)
//   ACK_*       3-bit downstream acknowledge codes
//   ERR_*       2-bit drop reasons reported on err_code
//   ROU_*_LSB   field offsets of the default-width flit {kind,cmd,addr,data}
//   rou_tx_state_e  tx stage FSM state encoding
package rou_pkg;

  localparam logic [1:0] KIND_EMPTY = 2'b00;
  localparam logic [1:0] KIND_WRITE = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_RESP  = 2'b11;

  localparam logic [2:0] ACK_NONE   = 3'b000;
  localparam logic [2:0] ACK_ACCEPT = 3'b001;
  localparam logic [2:0] ACK_RETRY  = 3'b010;
  localparam logic [2:0] ACK_ERROR  = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ACK     = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int ROU_DWID     = 128;
  localparam int ROU_AWID     = 32;
  localparam int ROU_CWID     = 8;
  localparam int ROU_DATA_LSB = 0;
  localparam int ROU_ADDR_LSB = ROU_DWID;
  localparam int ROU_CMD_LSB  = ROU_DWID + ROU_AWID;
  localparam int ROU_KIND_LSB = ROU_DWID + ROU_AWID + ROU_CWID;
  localparam int ROU_WID      = ROU_KIND_LSB + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_BACKOFF = 2'd2
  } rou_tx_state_e;

  // Every non-zero code other than ACCEPT/RETRY is treated as an error ack.
  function automatic logic is_err_ack(input logic [2:0] ack);
    return (ack != ACK_NONE) && (ack != ACK_ACCEPT) && (ack != ACK_RETRY);
  endfunction

endpackage

// File: rtl/rou_req_fifo.sv
// rou_req_fifo: DEPTH x WID synchronous request FIFO for the roubus tx stage.
//   clk, rst_n  clock, synchronous active-low reset (pointers/count cleared)
//   push, wdata write side; ignored when full
//   pop         read side; ignored when empty
//   head        entry at the read pointer
//   head_next   entry behind the head, valid when count >= 2
//   count       number of stored entries (0..DEPTH)
module rou_req_fifo #(
  parameter int WID   = 170,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WID-1:0]         wdata,
  input  logic                   pop,
  output logic [WID-1:0]         head,
  output logic [WID-1:0]         head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WID-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign do_push = push && (count_q < CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_q + AW'(1)];
  assign count     = count_q;

endmodule

// File: rtl/rou_tx_stage.sv
// rou_tx_stage: initiator-side roubus stage. Queues local requests, drives one
// flit {kind,cmd,addr,data} at a time on rou_out until it is acked, re-sends
// after a back-off on RETRY and reports completion or drop per flit.
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid/ready    request handshake; kind 00 completes but is discarded
//   req_kind/cmd/addr/data  request fields
//   rou_out            registered flit, all-zero when the bus is empty
//   ack_out            downstream ack: 001 accept, 010 retry, other non-zero error
//   done_pulse         one cycle after the head flit is accepted
//   err_pulse/err_code one cycle after the head flit is dropped, with reason
//   busy               requests queued or a flit in flight
// Optional: define ROU_TX_TIMEOUT_EN to drop a flit after TIMEOUT SEND cycles
// without any ack (err_code 11). Without it SEND waits indefinitely.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | bus empty, waiting for the FIFO to hold a request
// ST_SEND    | head flit on rou_out, waiting for ack
// ST_BACKOFF | bus empty after RETRY, counting down before resend
module rou_tx_stage
  import rou_pkg::*;
#(
  parameter int DWID      = 128,
  parameter int AWID      = 32,
  parameter int CWID      = 8,
  parameter int WID       = 2 + DWID + AWID + CWID,
  parameter int DEPTH     = 4,
  parameter int BACKOFF   = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [CWID-1:0] req_cmd,
  input  logic [AWID-1:0] req_addr,
  input  logic [DWID-1:0] req_data,
  output logic [WID-1:0]  rou_out,
  input  logic [2:0]      ack_out,
  output logic            done_pulse,
  output logic            err_pulse,
  output logic [1:0]      err_code,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int BW = $clog2(BACKOFF + 1);

  rou_tx_state_e  state_q, state_d;
  logic [WID-1:0] flit_q, flit_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [BW-1:0]  bo_q, bo_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;

  logic [WID-1:0] fifo_head, fifo_head_next;
  logic [CW-1:0]  fifo_count;
  logic           fifo_push, fifo_pop;

  logic in_send, ack_accept, ack_retry, ack_error, retry_left, tmo_hit;
  logic send_end, has_next, fifo_nonempty;

`ifdef ROU_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign req_ready = rst_n && (fifo_count < CW'(DEPTH));
  assign fifo_push = req_valid && req_ready && (req_kind != KIND_EMPTY);

  rou_req_fifo #(
    .WID   (WID),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .wdata     ({req_kind, req_cmd, req_addr, req_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .count     (fifo_count)
  );

  assign in_send       = (state_q == ST_SEND);
  assign ack_accept    = in_send && (ack_out == ACK_ACCEPT);
  assign ack_retry     = in_send && (ack_out == ACK_RETRY);
  assign ack_error     = in_send && is_err_ack(ack_out);
  assign retry_left    = (retry_q < RW'(MAX_RETRY));
  assign fifo_nonempty = (fifo_count != '0);
  // Next head is only taken from entries already stored; a same-edge push
  // into a one-entry FIFO waits for IDLE to load it.
  assign has_next      = (fifo_count > CW'(1));

`ifdef ROU_TX_TIMEOUT_EN
  assign tmo_hit = in_send && (ack_out == ACK_NONE) && (tmo_q == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  // Head flit leaves the FIFO: accepted, error ack, retries spent or timeout.
  assign send_end = ack_accept || ack_error || (ack_retry && !retry_left) || tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flit_q  <= '0;
      retry_q <= '0;
      bo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
`ifdef ROU_TX_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      retry_q <= retry_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef ROU_TX_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (send_end)       state_d = has_next ? ST_SEND : ST_IDLE;
        else if (ack_retry) state_d = ST_BACKOFF;
      end
      ST_BACKOFF: begin
        if (bo_q == '0) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flit_d   = flit_q;
    retry_d  = retry_q;
    bo_d     = bo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    fifo_pop = 1'b0;
`ifdef ROU_TX_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          flit_d = fifo_head;
`ifdef ROU_TX_TIMEOUT_EN
          tmo_d  = TW'(TIMEOUT - 1);
`endif
        end else begin
          flit_d = '0;
        end
      end
      ST_SEND: begin
        if (send_end) begin
          fifo_pop = 1'b1;
          retry_d  = '0;
          if (ack_accept) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (ack_error)      code_d = ERR_ACK;
            else if (ack_retry) code_d = ERR_RETRY;
            else                code_d = ERR_TIMEOUT;
          end
          if (has_next) begin
            flit_d = fifo_head_next;
`ifdef ROU_TX_TIMEOUT_EN
            tmo_d  = TW'(TIMEOUT - 1);
`endif
          end else begin
            flit_d = '0;
          end
        end else if (ack_retry) begin
          retry_d = retry_q + RW'(1);
          flit_d  = '0;
          // Loaded with BACKOFF-1 so the bus stays empty exactly BACKOFF cycles.
          bo_d    = BW'(BACKOFF - 1);
        end else begin
`ifdef ROU_TX_TIMEOUT_EN
          tmo_d = tmo_q - TW'(1);
`endif
        end
      end
      ST_BACKOFF: begin
        if (bo_q == '0) begin
          flit_d = fifo_head;
`ifdef ROU_TX_TIMEOUT_EN
          tmo_d  = TW'(TIMEOUT - 1);
`endif
        end else begin
          bo_d = bo_q - BW'(1);
        end
      end
      default: flit_d = '0;
    endcase
  end

  assign rou_out    = flit_q;
  assign done_pulse = done_q;
  assign err_pulse  = err_q;
  assign err_code   = code_q;
  assign busy       = fifo_nonempty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_rou_tx_stage.sv
module tb_rou_tx_stage;

  localparam int DWID      = 128;
  localparam int AWID      = 32;
  localparam int CWID      = 8;
  localparam int WID       = 2 + DWID + AWID + CWID;
  localparam int DEPTH     = 4;
  localparam int BACKOFF   = 4;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 8;
`ifdef ROU_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_kind;
  logic [CWID-1:0] req_cmd;
  logic [AWID-1:0] req_addr;
  logic [DWID-1:0] req_data;
  logic [WID-1:0]  rou_out;
  logic [2:0]      ack_out;
  logic            done_pulse;
  logic            err_pulse;
  logic [1:0]      err_code;
  logic            busy;

  int checks = 0;
  int errors = 0;

  rou_tx_stage #(
    .DWID(DWID), .AWID(AWID), .CWID(CWID), .DEPTH(DEPTH),
    .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rou_out    (rou_out),
    .ack_out    (ack_out),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [WID-1:0] mk(input logic [1:0] k, input logic [CWID-1:0] c,
                                        input logic [AWID-1:0] a, input logic [DWID-1:0] d);
    return {k, c, a, d};
  endfunction

  // Behavioural model: queue of pending flits plus what the bus should show.
  logic [WID-1:0] mq[$];
  bit   on_bus = 0;
  int   gap = 0;
  int   tries = 0;
  int   waited = 0;
  bit   exp_done = 0;
  bit   exp_err = 0;
  logic [1:0] exp_code = 2'b00;
  bit   model_live = 0;

  always @(posedge clk) begin : model
    bit fin;
    int n0;
    if (!rst_n) begin
      mq.delete();
      on_bus = 0; gap = 0; tries = 0; waited = 0;
      exp_done = 0; exp_err = 0; exp_code = 2'b00;
    end else begin
      exp_done = 0; exp_err = 0; exp_code = 2'b00;
      fin = 0;
      n0 = mq.size();
      if (on_bus) begin
        waited++;
        if (ack_out == 3'b001) begin
          exp_done = 1; fin = 1;
        end else if (ack_out == 3'b010) begin
          if (tries < MAX_RETRY) begin
            tries++; on_bus = 0; gap = BACKOFF;
          end else begin
            exp_err = 1; exp_code = 2'b10; fin = 1;
          end
        end else if (ack_out != 3'b000) begin
          exp_err = 1; exp_code = 2'b01; fin = 1;
        end else if (TMO_EN && waited == TIMEOUT) begin
          exp_err = 1; exp_code = 2'b11; fin = 1;
        end
        if (fin) begin
          void'(mq.pop_front());
          tries = 0;
          waited = 0;
          on_bus = (mq.size() > 0);
        end
      end else if (gap > 0) begin
        gap--;
        if (gap == 0) begin on_bus = 1; waited = 0; end
      end else if (mq.size() > 0) begin
        on_bus = 1; waited = 0;
      end
      if (req_valid && n0 < DEPTH && req_kind != 2'b00)
        mq.push_back(mk(req_kind, req_cmd, req_addr, req_data));
    end
    model_live = 1;
  end

  int done_seen = 0;
  int err_seen = 0;
  int send_cycles = 0;
  logic [1:0] last_code = 2'b00;

  always @(negedge clk) begin
    if (model_live) begin
      chk("rou_out", rou_out, on_bus ? mq[0] : '0);
      chk("done_pulse", WID'(done_pulse), WID'(exp_done));
      chk("err_pulse", WID'(err_pulse), WID'(exp_err));
      chk("err_code", WID'(err_code), WID'(exp_code));
      chk("busy", WID'(busy), WID'((mq.size() > 0) || on_bus || (gap > 0)));
      chk("req_ready", WID'(req_ready), WID'(rst_n && (mq.size() < DEPTH)));
      if (done_pulse) done_seen++;
      if (err_pulse) begin err_seen++; last_code = err_code; end
      if (rou_out[WID-1 -: 2] != 2'b00) send_cycles++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic v, input logic [1:0] k, input logic [AWID-1:0] a, input logic [DWID-1:0] d);
    req_valid = v;
    req_kind  = k;
    req_cmd   = 8'h5A;
    req_addr  = a;
    req_data  = d;
  endtask

  logic [WID-1:0] fa, f1, f2, f3, f4, fr, fb, ft;

  initial begin
    rst_n = 1'b0;
    ack_out = 3'b000;
    offer(1'b0, 2'b00, '0, '0);
    cyc(); cyc();
    chk("rst_rou_out", rou_out, '0);
    chk("rst_ready_low", WID'(req_ready), '0);
    chk("rst_busy", WID'(busy), '0);
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", WID'(req_ready), WID'(1));

    // 1: single write, accepted on the third SEND cycle
    fa = {2'b01, 8'h00, 32'h10, 128'hAB};
    req_valid = 1'b1; req_kind = 2'b01; req_cmd = 8'h00; req_addr = 32'h10; req_data = 128'hAB;
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("t1_load", rou_out, fa);
    cyc(); cyc();
    chk("t1_hold", rou_out, fa);
    ack_out = 3'b001;
    cyc();
    chk("t1_done", WID'(done_pulse), WID'(1));
    chk("t1_kind_empty", WID'(rou_out[WID-1 -: 2]), '0);
    ack_out = 3'b000;
    cyc();
    chk("t1_done_once", WID'(done_pulse), '0);

    // 2: fill the FIFO, then drain with ack every cycle
    done_seen = 0;
    f1 = mk(2'b01, 8'h5A, 32'h100, 128'h1);
    f2 = mk(2'b10, 8'h5A, 32'h104, 128'h2);
    f3 = mk(2'b11, 8'h5A, 32'h108, 128'h3);
    f4 = mk(2'b01, 8'h5A, 32'h10C, 128'h4);
    offer(1'b1, 2'b01, 32'h100, 128'h1); cyc();
    offer(1'b1, 2'b10, 32'h104, 128'h2); cyc();
    offer(1'b1, 2'b11, 32'h108, 128'h3); cyc();
    offer(1'b1, 2'b01, 32'h10C, 128'h4); cyc();
    chk("t2_full_ready", WID'(req_ready), '0);
    chk("t2_first", rou_out, f1);
    offer(1'b0, 2'b00, '0, '0);
    ack_out = 3'b001;
    cyc();
    chk("t2_b2b", rou_out, f2);
    chk("t2_ready_back", WID'(req_ready), WID'(1));
    cyc();
    chk("t2_third", rou_out, f3);
    cyc();
    chk("t2_fourth", rou_out, f4);
    cyc();
    ack_out = 3'b000;
    cyc();
    chk("t2_done_count", WID'(done_seen), WID'(4));
    chk("t2_idle", rou_out, '0);

    // 3: retry every send until exhausted
    done_seen = 0; err_seen = 0; send_cycles = 0;
    fr = mk(2'b01, 8'h5A, 32'h200, 128'hCAFE);
    offer(1'b1, 2'b01, 32'h200, 128'hCAFE);
    ack_out = 3'b010;
    cyc();
    offer(1'b0, 2'b00, '0, '0);
    cyc();
    chk("t3_send1", rou_out, fr);
    cyc();
    chk("t3_gap", rou_out, '0);
    repeat (3) cyc();
    chk("t3_gap_end", rou_out, '0);
    cyc();
    chk("t3_send2", rou_out, fr);
    repeat (14) cyc();
    ack_out = 3'b000;
    chk("t3_sends", WID'(send_cycles), WID'(4));
    chk("t3_err_count", WID'(err_seen), WID'(1));
    chk("t3_err_code", WID'(last_code), WID'(2'b10));
    chk("t3_no_done", WID'(done_seen), '0);
    cyc();

    // 4: error ack on the first flit, second flit follows immediately
    fb = mk(2'b01, 8'h5A, 32'h304, 128'hB);
    offer(1'b1, 2'b10, 32'h300, 128'hA); cyc();
    offer(1'b1, 2'b01, 32'h304, 128'hB); cyc();
    offer(1'b0, 2'b00, '0, '0);
    ack_out = 3'b100;
    cyc();
    chk("t4_err", WID'(err_pulse), WID'(1));
    chk("t4_code", WID'(err_code), WID'(2'b01));
    chk("t4_next", rou_out, fb);
    ack_out = 3'b001;
    cyc();
    chk("t4_done", WID'(done_pulse), WID'(1));
    chk("t4_code_clear", WID'(err_code), '0);
    ack_out = 3'b000;
    cyc();

    // kind 00 completes the handshake but is never sent
    offer(1'b1, 2'b00, 32'h400, 128'h9); cyc();
    offer(1'b0, 2'b00, '0, '0); cyc();
    chk("ill_busy", WID'(busy), '0);
    chk("ill_bus", rou_out, '0);

    // 5: reset mid-SEND with requests queued
    offer(1'b1, 2'b01, 32'h500, 128'h1); cyc();
    offer(1'b1, 2'b01, 32'h504, 128'h2); cyc();
    offer(1'b1, 2'b01, 32'h508, 128'h3); cyc();
    offer(1'b0, 2'b00, '0, '0);
    rst_n = 1'b0;
    ack_out = 3'b001;
    cyc();
    chk("t5_bus", rou_out, '0);
    chk("t5_busy", WID'(busy), '0);
    chk("t5_no_done", WID'(done_pulse), '0);
    rst_n = 1'b1;
    ack_out = 3'b000;
    cyc();
    chk("t5_no_err", WID'(err_pulse), '0);
    chk("t5_ready", WID'(req_ready), WID'(1));

    // 6: ack stuck at 000
    err_seen = 0;
    ft = mk(2'b10, 8'h5A, 32'h600, 128'h66);
    offer(1'b1, 2'b10, 32'h600, 128'h66); cyc();
    offer(1'b0, 2'b00, '0, '0); cyc();
`ifdef ROU_TX_TIMEOUT_EN
    repeat (7) cyc();
    chk("t6_pre_tmo", rou_out, ft);
    chk("t6_pre_err", WID'(err_pulse), '0);
    cyc();
    chk("t6_err", WID'(err_pulse), WID'(1));
    chk("t6_code", WID'(err_code), WID'(2'b11));
    cyc();
    chk("t6_idle", WID'(busy), '0);
`else
    repeat (110) cyc();
    chk("t6_held", rou_out, ft);
    chk("t6_no_err", WID'(err_seen), '0);
    chk("t6_busy", WID'(busy), WID'(1));
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
